// File: rtl/display_capture_pkg.sv
// Shared constants for the 7-segment capture path: segment table (same as hex2seg),
// legal digit codes, FSM encoding and the small decode structs/helpers.
package display_capture_pkg;

  localparam logic [7:0] DIGIT_IDLE = 8'hFF;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Legal active-low digit enables, index = slot number.
  localparam logic [7:0] DIGIT_SEL [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

  // Segments a..g (a = MSB), active low, index = hex nibble.
  localparam logic [6:0] SEG7 [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_SAMPLED = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } seg_dec_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] slot;
  } digit_dec_t;

  function automatic digit_dec_t decode_digit(input logic [7:0] digit);
    digit_dec_t d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (digit == DIGIT_SEL[i]) begin
        d.legal = 1'b1;
        d.slot  = 2'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/display_capture_if.sv
// Pin-level display lines plus the reassembled capture results.
interface display_capture_if;

  logic [7:0]  digit;
  logic [7:0]  segment;
  logic        errClr;
  logic [15:0] capVal;
  logic [3:0]  capPoint;
  logic        capValid;
  logic        patErr;
  logic        digErr;
  logic        capStale;

  modport master (
    output digit, segment, errClr,
    input  capVal, capPoint, capValid, patErr, digErr, capStale
  );

  modport slave (
    input  digit, segment, errClr,
    output capVal, capPoint, capValid, patErr, digErr, capStale
  );

endinterface

// File: rtl/display_capture_seg2hex.sv
// Combinational inverse of hex2seg: active-low a..g pattern -> {hit, nibble}.
module seg2hex
  import display_capture_pkg::*;
(
  input  logic [6:0] pattern_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG7[i]) begin
        dec_o.hit    = 1'b1;
        dec_o.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/display_capture.sv
// Watches the multiplexed 7-segment lines, samples each settled dwell once and
// reassembles complete 4-digit frames; flags bad patterns, bad digit codes and staleness.
module display_capture
  import display_capture_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 16384
) (
  input  logic             clk5,
  input  logic             reset,
  display_capture_if.slave bus
);

  localparam int SW = $clog2(SETTLE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
  localparam logic [15:0]   PINS_IDLE   = {DIGIT_IDLE, SEG_BLANK};

  // {digit, segment}: two synchroniser stages plus one history stage for change detect.
  logic [15:0] meta_q, sync_q, last_q;
  logic        change;
  logic [7:0]  digit_s, seg_s;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          take;

  digit_dec_t dig_dec;
  seg_dec_t   seg_dec;
  logic       sample_ok, pat_set, dig_set, commit;

  logic [3:0][3:0] shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_pt_q, shadow_pt_d;
  logic [3:0]      mask_q, mask_d;
  logic [15:0]     cap_val_q, cap_val_d;
  logic [3:0]      cap_pt_q, cap_pt_d;
  logic            cap_valid_q, cap_valid_d;
  logic            pat_err_q, pat_err_d;
  logic            dig_err_q, dig_err_d;
  logic            stale_q, stale_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      meta_q <= PINS_IDLE;
      sync_q <= PINS_IDLE;
      last_q <= PINS_IDLE;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's pre-edge value.
      meta_q <= {bus.digit, bus.segment};
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign change  = (sync_q != last_q);
  assign digit_s = sync_q[15:8];
  assign seg_s   = sync_q[7:0];

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (change) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (change) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          take    = 1'b1;
          state_d = ST_SAMPLED;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_SAMPLED: begin
        if (change) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  assign dig_dec = decode_digit(digit_s);

  seg2hex u_seg2hex (
    .pattern_i (seg_s[7:1]),
    .dec_o     (seg_dec)
  );

  assign sample_ok = take & dig_dec.legal & seg_dec.hit;
  assign pat_set   = take & dig_dec.legal & ~seg_dec.hit;
  assign dig_set   = take & ~dig_dec.legal;
  assign commit    = (mask_q == 4'hF);

  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_pt_d  = shadow_pt_q;
    mask_d       = commit ? 4'h0 : mask_q;
    cap_val_d    = commit ? shadow_val_q : cap_val_q;
    cap_pt_d     = commit ? shadow_pt_q : cap_pt_q;
    cap_valid_d  = commit;

    if (sample_ok) begin
      shadow_val_d[dig_dec.slot] = seg_dec.nibble;
      shadow_pt_d[dig_dec.slot]  = ~seg_s[0];
      mask_d[dig_dec.slot]       = 1'b1;
    end

    if (sample_ok)                     to_cnt_d = '0;
    else if (to_cnt_q == TIMEOUT_MAX)  to_cnt_d = to_cnt_q;
    else                               to_cnt_d = to_cnt_q + TW'(1);

    // Stale is only released by a commit, never by the counter dropping back.
    if (commit)                        stale_d = 1'b0;
    else if (to_cnt_d == TIMEOUT_MAX)  stale_d = 1'b1;
    else                               stale_d = stale_q;

    pat_err_d = pat_set | (pat_err_q & ~bus.errClr);
    dig_err_d = dig_set | (dig_err_q & ~bus.errClr);
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      shadow_val_q <= '0;
      shadow_pt_q  <= '0;
      mask_q       <= '0;
      cap_val_q    <= '0;
      cap_pt_q     <= '0;
      cap_valid_q  <= 1'b0;
      pat_err_q    <= 1'b0;
      dig_err_q    <= 1'b0;
      stale_q      <= 1'b1;
      to_cnt_q     <= '0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_pt_q  <= shadow_pt_d;
      mask_q       <= mask_d;
      cap_val_q    <= cap_val_d;
      cap_pt_q     <= cap_pt_d;
      cap_valid_q  <= cap_valid_d;
      pat_err_q    <= pat_err_d;
      dig_err_q    <= dig_err_d;
      stale_q      <= stale_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.capVal   = cap_val_q;
  assign bus.capPoint = cap_pt_q;
  assign bus.capValid = cap_valid_q;
  assign bus.patErr   = pat_err_q;
  assign bus.digErr   = dig_err_q;
  assign bus.capStale = stale_q;

endmodule

// File: tb/tb_display_capture.sv
// Scenario bench for display_capture: a small dwell model pushes expected frames,
// a negedge monitor pops them on every capValid pulse.
module tb_display_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 16384;
  localparam int DWELL   = 40;
  localparam int MIN_DW  = 24;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  pt;
  } frame_t;

  logic clk5  = 1'b0;
  logic reset = 1'b1;

  display_capture_if bus ();

  display_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk5  (clk5),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk5 = ~clk5;

  logic [6:0] seg_tab [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  frame_t      exp_q [$];
  logic [15:0] m_val  = '0;
  logic [3:0]  m_pt   = '0;
  logic [3:0]  m_mask = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] dsel(input int i);
    return 8'hFF ^ (8'h01 << i);
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] n, input logic p);
    return {seg_tab[n], ~p};
  endfunction

  // Frame scoreboard: every capValid must match the oldest expected frame.
  always @(negedge clk5) begin
    if (bus.capValid) begin
      frame_t f;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_capValid got val=%h pt=%b want no frame", bus.capVal, bus.capPoint);
      end else begin
        f = exp_q.pop_front();
        if ({bus.capVal, bus.capPoint} !== {f.val, f.pt}) begin
          errors++;
          $display("FAIL frame got val=%h pt=%b want val=%h pt=%b",
                   bus.capVal, bus.capPoint, f.val, f.pt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic dwell_start(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
    int         slot;
    logic       hit;
    logic [3:0] nib;
    slot = -1;
    hit  = 1'b0;
    nib  = '0;
    for (int i = 0; i < 4; i++) if (dig == dsel(i)) slot = i;
    for (int i = 0; i < 16; i++) begin
      if (seg[7:1] == seg_tab[i]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    end
    if (cycles >= MIN_DW && slot >= 0 && hit) begin
      m_val[slot*4 +: 4] = nib;
      m_pt[slot]         = ~seg[0];
      m_mask[slot]       = 1'b1;
      if (m_mask == 4'hF) begin
        exp_q.push_back({m_val, m_pt});
        m_mask = '0;
      end
    end
    @(negedge clk5);
    bus.digit   = dig;
    bus.segment = seg;
  endtask

  task automatic dwell(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
    dwell_start(dig, seg, cycles);
    repeat (cycles - 1) @(negedge clk5);
  endtask

  task automatic frame(input logic [15:0] val, input logic [3:0] pt);
    for (int i = 0; i < 4; i++) dwell(dsel(i), enc(val[i*4 +: 4], pt[i]), DWELL);
  endtask

  task automatic pulse_errclr();
    @(negedge clk5);
    bus.errClr = 1'b1;
    @(negedge clk5);
    bus.errClr = 1'b0;
    @(negedge clk5);
  endtask

  task automatic test_reset();
    bus.digit   = 8'hFF;
    bus.segment = 8'hFF;
    bus.errClr  = 1'b0;
    reset       = 1'b1;
    m_mask      = '0;
    repeat (3) @(negedge clk5);
    checks++;
    if ({bus.capVal, bus.capPoint, bus.capValid, bus.patErr, bus.digErr, bus.capStale} !== 24'h000001) begin
      errors++;
      $display("FAIL reset_in got %h want %h",
               {bus.capVal, bus.capPoint, bus.capValid, bus.patErr, bus.digErr, bus.capStale}, 24'h000001);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk5);
    checks++;
    if ({bus.capVal, bus.capPoint, bus.capValid, bus.patErr, bus.digErr, bus.capStale} !== 24'h000001) begin
      errors++;
      $display("FAIL reset_out got %h want %h",
               {bus.capVal, bus.capPoint, bus.capValid, bus.patErr, bus.digErr, bus.capStale}, 24'h000001);
    end
  endtask

  task automatic test_loopback();
    frame(16'hA5C3, 4'b0101);
    frame(16'hA5C3, 4'b0101);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL loopback_pending got %0d frames outstanding want 0", exp_q.size());
    end
    checks++;
    if ({bus.capVal, bus.capPoint, bus.patErr, bus.digErr, bus.capStale} !== {16'hA5C3, 4'b0101, 3'b000}) begin
      errors++;
      $display("FAIL loopback_out got val=%h pt=%b pe=%b de=%b st=%b want val=a5c3 pt=0101 flags 000",
               bus.capVal, bus.capPoint, bus.patErr, bus.digErr, bus.capStale);
    end
  endtask

  task automatic test_settle();
    for (int k = 0; k < 25; k++) dwell(8'hFE, (k % 2 == 1) ? 8'h9F : 8'h03, 8);
    dwell(8'hFE, 8'h9F, DWELL);
    checks++;
    if (bus.patErr !== 1'b0) begin
      errors++;
      $display("FAIL settle_paterr got %b want 0", bus.patErr);
    end
    dwell(dsel(1), enc(4'h2, 1'b1), DWELL);
    dwell(dsel(2), enc(4'h3, 1'b1), DWELL);
    dwell(dsel(3), enc(4'h4, 1'b1), DWELL);
    checks++;
    if ({bus.capVal, bus.capPoint} !== {16'h4321, 4'b1110}) begin
      errors++;
      $display("FAIL settle_frame got val=%h pt=%b want val=4321 pt=1110", bus.capVal, bus.capPoint);
    end
  endtask

  task automatic test_pattern_error();
    dwell(dsel(0), enc(4'h7, 1'b1), DWELL);
    dwell(dsel(1), 8'hFF, DWELL);
    dwell(dsel(2), enc(4'h8, 1'b0), DWELL);
    dwell(dsel(3), enc(4'h9, 1'b0), DWELL);
    checks++;
    if (bus.patErr !== 1'b1 || bus.capVal !== 16'h4321) begin
      errors++;
      $display("FAIL pat_detect got pe=%b val=%h want pe=1 val=4321", bus.patErr, bus.capVal);
    end
    dwell(dsel(1), enc(4'hE, 1'b0), DWELL);
    checks++;
    if ({bus.capVal, bus.capPoint, bus.patErr} !== {16'h98E7, 4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL pat_refill got val=%h pt=%b pe=%b want val=98e7 pt=0001 pe=1",
               bus.capVal, bus.capPoint, bus.patErr);
    end
    pulse_errclr();
    checks++;
    if (bus.patErr !== 1'b0) begin
      errors++;
      $display("FAIL pat_clear got %b want 0", bus.patErr);
    end
  endtask

  task automatic test_digit_error();
    dwell(dsel(0), enc(4'hB, 1'b0), DWELL);
    dwell(8'hFC, enc(4'h5, 1'b0), 100);
    checks++;
    if (bus.digErr !== 1'b1 || bus.patErr !== 1'b0) begin
      errors++;
      $display("FAIL dig_detect got de=%b pe=%b want de=1 pe=0", bus.digErr, bus.patErr);
    end
    dwell(dsel(1), enc(4'hC, 1'b0), DWELL);
    dwell(dsel(2), enc(4'hD, 1'b0), DWELL);
    dwell(dsel(3), enc(4'hF, 1'b0), DWELL);
    checks++;
    if ({bus.capVal, bus.capPoint} !== {16'hFDCB, 4'b0000}) begin
      errors++;
      $display("FAIL dig_frame got val=%h pt=%b want val=fdcb pt=0000", bus.capVal, bus.capPoint);
    end
    pulse_errclr();
    checks++;
    if (bus.digErr !== 1'b0) begin
      errors++;
      $display("FAIL dig_clear got %b want 0", bus.digErr);
    end
  endtask

  task automatic test_timeout();
    int n;
    dwell(dsel(0), enc(4'hB, 1'b0), DWELL);
    dwell(dsel(1), enc(4'h0, 1'b1), DWELL);
    dwell(dsel(2), enc(4'hE, 1'b0), DWELL);
    dwell_start(dsel(3), enc(4'h6, 1'b1), DWELL);
    n = 0;
    while (bus.capValid !== 1'b1 && n < 200) begin
      @(negedge clk5);
      n++;
    end
    checks++;
    if (n >= 200 || bus.capStale !== 1'b0) begin
      errors++;
      $display("FAIL timeout_commit got wait=%0d stale=%b want commit with stale=0", n, bus.capStale);
    end
    n = 0;
    while (bus.capStale !== 1'b1 && n < TIMEOUT + 50) begin
      @(negedge clk5);
      n++;
    end
    checks++;
    if (n < TIMEOUT - 2 || n > TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles want %0d..%0d", n, TIMEOUT - 2, TIMEOUT);
    end
    checks++;
    if ({bus.capVal, bus.capPoint} !== {16'h6E0B, 4'b1010}) begin
      errors++;
      $display("FAIL timeout_hold got val=%h pt=%b want val=6e0b pt=1010", bus.capVal, bus.capPoint);
    end
    dwell(dsel(0), enc(4'h8, 1'b1), DWELL);
    dwell(dsel(1), enc(4'h6, 1'b0), DWELL);
    dwell(dsel(2), enc(4'h4, 1'b0), DWELL);
    checks++;
    if (bus.capStale !== 1'b1) begin
      errors++;
      $display("FAIL timeout_partial got stale=%b want 1", bus.capStale);
    end
    dwell(dsel(3), enc(4'h2, 1'b0), DWELL);
    checks++;
    if ({bus.capVal, bus.capPoint, bus.capStale} !== {16'h2468, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL timeout_recover got val=%h pt=%b st=%b want val=2468 pt=0001 st=0",
               bus.capVal, bus.capPoint, bus.capStale);
    end
  endtask

  task automatic test_reset_midframe();
    dwell(dsel(0), enc(4'hF, 1'b1), DWELL);
    dwell(dsel(1), enc(4'hF, 1'b1), DWELL);
    dwell(dsel(2), enc(4'hF, 1'b1), DWELL);
    test_reset();
    dwell(dsel(3), enc(4'h1, 1'b0), DWELL);
    checks++;
    if ({bus.capVal, bus.capStale} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL midframe_partial got val=%h st=%b want val=0000 st=1", bus.capVal, bus.capStale);
    end
    dwell(dsel(0), enc(4'h4, 1'b0), DWELL);
    dwell(dsel(1), enc(4'h3, 1'b0), DWELL);
    dwell(dsel(2), enc(4'h2, 1'b0), DWELL);
    checks++;
    if ({bus.capVal, bus.capPoint, bus.capStale} !== {16'h1234, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL midframe_fresh got val=%h pt=%b st=%b want val=1234 pt=0000 st=0",
               bus.capVal, bus.capPoint, bus.capStale);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_settle();
    test_pattern_error();
    test_digit_error();
    test_timeout();
    test_reset_midframe();
    repeat (5) @(negedge clk5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
